sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Owns the external SRAM pins and shares them between three requesters: the JTAG debug port, core data access (dmem) and core instruction fetch (imem). It serialises accesses and generates the SRAM chip timing (address setup, write strobe, data hold). It sits at processor top level between the requesters and the SRAM pad/tri-state logic.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
ACCESS_CYCLES, 2, cycles the strobe is held; legal range is 1 or more
MAX_STREAK, 4, consecutive non-imem grants allowed while imem is waiting

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
hold_core  in  1  1 = only JTAG may be granted (core paused)
jtag_req  in  1  JTAG access request, held until ack
jtag_wr  in  1  1 = write, 0 = read
jtag_addr  in  ADDR_W  JTAG address
jtag_wdata  in  DATA_W  JTAG write data
jtag_ack  out  1  one-cycle completion pulse to JTAG
dmem_req / dmem_wr / dmem_addr / dmem_wdata / dmem_ack  same widths and meaning as the jtag_ group
imem_req  in  1  fetch request (read only)
imem_addr  in  ADDR_W  fetch address
imem_ack  out  1  one-cycle completion pulse to imem
rd_data  out  DATA_W  read data shared by all requesters; valid only in the ack cycle
busy  out  1  1 = any state other than IDLE
grant_id  out  2  current owner: 0 none, 1 jtag, 2 dmem, 3 imem
sram_addr  out  ADDR_W  SRAM address pins
sram_wdata  out  DATA_W  data to the pad tri-state buffer
sram_oe  out  1  1 = pad drives sram_wdata onto the bus
sram_rdata  in  DATA_W  data sampled from the pad
sram_en  out  1  chip enable, active-high at this boundary
sram_wr  out  1  write strobe, active-high at this boundary

Behaviour:
- Reset (asynchronous, rst = 1): state IDLE, every output 0, streak counter 0, no ack issued. Reset mid-access aborts the access. A requester whose access is aborted must re-issue it.
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: when any request is eligible, pick a winner and latch its addr, wr and wdata. The next state is SETUP. If no request is eligible, stay in IDLE.
- SETUP (1 cycle):
  - sram_en = 1 and sram_addr = latched address.
  - sram_wr = 0.
  - sram_oe = wr.
- STROBE (ACCESS_CYCLES cycles, counted by a down-counter):
  - sram_en = 1.
  - sram_wr = wr.
  - sram_oe = wr.
- DONE (1 cycle):
  - sram_wr = 0; sram_en and sram_oe stay asserted for hold time.
  - For a read, rd_data is captured from sram_rdata at the last STROBE edge and is presented in DONE.
  - The winner's ack = 1 for exactly this cycle.
  - The next state is IDLE.
- Timing: latency from a request sampled in IDLE to ack is ACCESS_CYCLES+2 cycles. Minimum spacing between accesses is ACCESS_CYCLES+3 cycles.
- grant_id holds the owner from SETUP through DONE. It is 0 in IDLE.
- sram_addr and sram_wdata keep their last values while idle. rd_data holds its last captured value.
- Priority: JTAG > dmem > imem. When hold_core = 1, dmem and imem are ineligible.
- Anti-starvation:
  - The streak counter increments on each jtag or dmem grant made while imem_req = 1 and imem is eligible.
  - When streak = MAX_STREAK and imem is eligible, imem wins over dmem.
  - JTAG always wins.
  - An imem grant clears the streak. The streak also clears whenever imem_req = 0 in IDLE.
- A request dropped mid-access does not stop the access. It completes, and ack is still pulsed.
- Requesters must hold req, addr, wr and wdata stable until ack. These inputs are latched at grant, so later changes are ignored.
- A requester still asserting req in the DONE cycle is treated as a new request. It is re-arbitrated in the following IDLE cycle.
- A change in hold_core during an access does not affect that access.

Decomposition:
- Shared package holds:
  - grant id constants GNT_NONE = 0, GNT_JTAG = 1, GNT_DMEM = 2, GNT_IMEM = 3.
  - State encoding constants for IDLE, SETUP, STROBE, DONE.
- Sub-module sram_arb_pick: combinational priority and starvation picker. Inputs are the three reqs, hold_core and streak_full. Output is the winner id. It is verified standalone.
- Sequencing FSM, counters and latches stay in sram_arbiter.

Test Plan:
- JTAG write, addr 0x0010, data 0xBEEF, ACCESS_CYCLES = 2 -> sram_en high for 4 cycles, sram_wr high exactly 2 cycles, sram_oe high for 4 cycles, jtag_ack pulses at cycle 4 after the request; a later read of 0x0010 returns rd_data 0xBEEF (SRAM model).
- JTAG, dmem and imem all request in the same cycle -> grants in order 1, 2, 3, spaced 5 cycles apart; exactly one ack per requester.
- dmem held continuously with imem_req = 1, MAX_STREAK = 4 -> 4 dmem grants, then 1 imem grant, then dmem resumes.
- hold_core = 1 with dmem and imem requesting -> no grant and busy = 0; a JTAG request is still serviced; dropping hold_core -> dmem is granted next.
- rst asserted during STROBE of a dmem write -> all outputs 0 asynchronously and no dmem_ack; after release, the dmem request is serviced from SETUP.
- ACCESS_CYCLES = 1, imem read of 0xFFFF -> ack at cycle 3; sram_wr stays 0 throughout; rd_data equals the model contents.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared grant identifiers and sequencer state encoding for the SRAM arbiter.
package sram_arbiter_pkg;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_JTAG = 2'd1;
  localparam logic [1:0] GNT_DMEM = 2'd2;
  localparam logic [1:0] GNT_IMEM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select: JTAG > dmem > imem, imem promoted over dmem once
// the starvation streak is full; hold_core leaves only JTAG eligible.
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic       jtag_req_i,
  input  logic       dmem_req_i,
  input  logic       imem_req_i,
  input  logic       hold_core_i,
  input  logic       streak_full_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (jtag_req_i) begin
      gnt_o = GNT_JTAG;
    end else if (!hold_core_i) begin
      if (imem_req_i && streak_full_i) begin
        gnt_o = GNT_IMEM;
      end else if (dmem_req_i) begin
        gnt_o = GNT_DMEM;
      end else if (imem_req_i) begin
        gnt_o = GNT_IMEM;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Three-way SRAM pin owner: IDLE -> SETUP -> STROBE x ACCESS_CYCLES -> DONE, ack in DONE.
// Request-to-ack latency ACCESS_CYCLES+2; back-to-back grants every ACCESS_CYCLES+3 cycles.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_STREAK    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_core,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_ack,
  input  logic              dmem_req,
  input  logic              dmem_wr,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_ack,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_en,
  output logic              sram_wr
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int SK_W  = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [SK_W-1:0]  SK_MAX   = SK_W'(MAX_STREAK);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SK_W-1:0]   streak_q, streak_d;
  logic              wr_q;
  logic [1:0]        gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_q;
  logic              en_q, oe_q, swr_q, busy_q;
  logic              jack_q, dack_q, iack_q;

  logic              streak_full;
  logic [1:0]        win;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              wr_d;

  assign streak_full = (streak_q >= SK_MAX);

  sram_arb_pick u_pick (
    .jtag_req_i    (jtag_req),
    .dmem_req_i    (dmem_req),
    .imem_req_i    (imem_req),
    .hold_core_i   (hold_core),
    .streak_full_i (streak_full),
    .gnt_o         (win)
  );

  // Fetches are read-only, so the write-data pins simply keep their previous value.
  always_comb begin
    addr_d  = jtag_addr;
    wdata_d = jtag_wdata;
    wr_d    = jtag_wr;
    case (win)
      GNT_DMEM: begin
        addr_d  = dmem_addr;
        wdata_d = dmem_wdata;
        wr_d    = dmem_wr;
      end
      GNT_IMEM: begin
        addr_d  = imem_addr;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
      end
      default: ;
    endcase
  end

  // Streak counts only grants that bypassed an eligible, waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (!imem_req || win == GNT_IMEM) begin
      streak_d = '0;
    end else if ((win == GNT_JTAG || win == GNT_DMEM) && !hold_core && !streak_full) begin
      streak_d = streak_q + SK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      streak_q <= '0;
      wr_q     <= 1'b0;
      gnt_q    <= GNT_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      en_q     <= 1'b0;
      oe_q     <= 1'b0;
      swr_q    <= 1'b0;
      busy_q   <= 1'b0;
      jack_q   <= 1'b0;
      dack_q   <= 1'b0;
      iack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          streak_q <= streak_d;
          if (win != GNT_NONE) begin
            state_q <= ST_SETUP;
            gnt_q   <= win;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= CNT_INIT;
            en_q    <= 1'b1;
            oe_q    <= wr_d;
            busy_q  <= 1'b1;
          end
        end
        ST_SETUP: begin
          state_q <= ST_STROBE;
          swr_q   <= wr_q;
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            swr_q   <= 1'b0;
            if (!wr_q) begin
              rd_q <= sram_rdata;
            end
            jack_q <= (gnt_q == GNT_JTAG);
            dack_q <= (gnt_q == GNT_DMEM);
            iack_q <= (gnt_q == GNT_IMEM);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
          gnt_q   <= GNT_NONE;
          jack_q  <= 1'b0;
          dack_q  <= 1'b0;
          iack_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign jtag_ack   = jack_q;
  assign dmem_ack   = dack_q;
  assign imem_ack   = iack_q;
  assign rd_data    = rd_q;
  assign busy       = busy_q;
  assign grant_id   = gnt_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_oe    = oe_q;
  assign sram_en    = en_q;
  assign sram_wr    = swr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (ACCESS_CYCLES 2 and 1) and the standalone picker.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2, hold_core;
  logic        jtag_req, jtag_wr, dmem_req, dmem_wr, imem_req;
  logic [15:0] jtag_addr, jtag_wdata, dmem_addr, dmem_wdata, imem_addr;

  logic        jtag_ack, dmem_ack, imem_ack, busy, sram_oe, sram_en, sram_wr;
  logic [1:0]  grant_id;
  logic [15:0] rd_data, sram_addr, sram_wdata, sram_rdata;

  logic        jtag_ack2, dmem_ack2, imem_ack2, busy2, sram_oe2, sram_en2, sram_wr2;
  logic [1:0]  grant_id2;
  logic [15:0] rd_data2, sram_addr2, sram_wdata2, sram_rdata2;

  logic        pk_j, pk_d, pk_i, pk_h, pk_f;
  logic [1:0]  pk_gnt;

  logic [15:0] mem [0:65535];
  assign sram_rdata  = mem[sram_addr];
  assign sram_rdata2 = mem[sram_addr2];

  int tests = 0;
  int fails = 0;

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(2), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst), .hold_core(hold_core),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_ack(jtag_ack),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .rd_data(rd_data), .busy(busy), .grant_id(grant_id),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_oe(sram_oe),
    .sram_rdata(sram_rdata), .sram_en(sram_en), .sram_wr(sram_wr)
  );

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(1), .MAX_STREAK(4)) dut2 (
    .clk(clk), .rst(rst2), .hold_core(hold_core),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_ack(jtag_ack2),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack2),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack2),
    .rd_data(rd_data2), .busy(busy2), .grant_id(grant_id2),
    .sram_addr(sram_addr2), .sram_wdata(sram_wdata2), .sram_oe(sram_oe2),
    .sram_rdata(sram_rdata2), .sram_en(sram_en2), .sram_wr(sram_wr2)
  );

  sram_arb_pick u_pick (
    .jtag_req_i(pk_j), .dmem_req_i(pk_d), .imem_req_i(pk_i),
    .hold_core_i(pk_h), .streak_full_i(pk_f), .gnt_o(pk_gnt)
  );

  // SRAM model: preloaded with addr ^ 0xA5A5, written on strobed edges of the main DUT.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    forever begin
      @(posedge clk);
      if (sram_en && sram_wr) mem[sram_addr] <= sram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int which);
    case (which)
      1: return jtag_ack;
      2: return dmem_ack;
      3: return imem_ack;
      default: return imem_ack2;
    endcase
  endfunction

  task automatic run_until_ack(input int which, output int at);
    at = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack_of(which)) begin
        at = c;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12 && busy; i++) tick();
    chk("idle_reached", {31'd0, busy}, 32'd0);
    tick();
  endtask

  logic [4:0] pv [7];
  logic [1:0] pe [7];
  logic [1:0] gid [8];
  int         gat [8];
  int         gn, at, en_n, wr_n, oe_n, ack_n, ja, da, ia, seen;
  logic [1:0] prev_g;
  logic [1:0] exp3 [6];

  initial begin
    rst = 1'b1; rst2 = 1'b1; hold_core = 1'b0;
    jtag_req = 0; jtag_wr = 0; jtag_addr = '0; jtag_wdata = '0;
    dmem_req = 0; dmem_wr = 0; dmem_addr = '0; dmem_wdata = '0;
    imem_req = 0; imem_addr = '0;
    {pk_j, pk_d, pk_i, pk_h, pk_f} = '0;
    repeat (2) tick();
    chk("rst_ctl", {24'd0, busy, sram_en, sram_wr, sram_oe, grant_id, jtag_ack, dmem_ack}, 32'd0);
    chk("rst_iack", {31'd0, imem_ack}, 32'd0);
    chk("rst_data", {sram_addr, rd_data | sram_wdata}, 32'd0);

    // Picker vectors {jtag, dmem, imem, hold, streak_full}
    pv = '{5'b11101, 5'b01100, 5'b01101, 5'b01111, 5'b00100, 5'b11110, 5'b00001};
    pe = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd1, 2'd0};
    for (int k = 0; k < 7; k++) begin
      {pk_j, pk_d, pk_i, pk_h, pk_f} = pv[k];
      #1;
      chk($sformatf("pick_%0d", k), {30'd0, pk_gnt}, {30'd0, pe[k]});
    end

    rst = 1'b0;
    tick();

    // JTAG write 0x0010 <= 0xBEEF, pin timing
    jtag_req = 1; jtag_wr = 1; jtag_addr = 16'h0010; jtag_wdata = 16'hBEEF;
    en_n = 0; wr_n = 0; oe_n = 0; ack_n = 0; at = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (sram_en) en_n++;
      if (sram_wr) wr_n++;
      if (sram_oe) oe_n++;
      if (c == 1) chk("wr_setup_pins", {sram_addr, sram_wdata}, {16'h0010, 16'hBEEF});
      if (c == 1) chk("wr_setup_gnt", {30'd0, grant_id}, 32'd1);
      if (jtag_ack) begin ack_n++; at = c; jtag_req = 0; end
    end
    chk("wr_en_cycles", en_n, 4);
    chk("wr_strobe_cycles", wr_n, 2);
    chk("wr_oe_cycles", oe_n, 4);
    chk("wr_ack_cycle", at, 4);
    chk("wr_ack_count", ack_n, 1);

    // JTAG read back
    jtag_wr = 0; jtag_req = 1;
    run_until_ack(1, at);
    chk("rd_ack_cycle", at, 4);
    chk("rd_data_beef", {16'd0, rd_data}, 32'h0000BEEF);
    jtag_req = 0;
    wait_idle();

    // All three request together
    jtag_req = 1; jtag_addr = 16'h0001;
    dmem_req = 1; dmem_wr = 0; dmem_addr = 16'h0002;
    imem_req = 1; imem_addr = 16'h0003;
    gn = 0; ja = 0; da = 0; ia = 0; prev_g = grant_id;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (prev_g == 2'd0 && grant_id != 2'd0 && gn < 8) begin gid[gn] = grant_id; gat[gn] = c; gn++; end
      prev_g = grant_id;
      if (jtag_ack) begin ja++; jtag_req = 0; end
      if (dmem_ack) begin da++; dmem_req = 0; end
      if (imem_ack) begin ia++; imem_req = 0; end
    end
    chk("all3_grants", gn, 3);
    chk("all3_order", {26'd0, gid[0], gid[1], gid[2]}, {26'd0, 2'd1, 2'd2, 2'd3});
    chk("all3_first_at", gat[0], 1);
    chk("all3_spacing", {gat[1] - gat[0], gat[2] - gat[1]}, {32'd5, 32'd5});
    chk("all3_acks", {ja[7:0], da[7:0], ia[7:0]}, {8'd1, 8'd1, 8'd1});
    wait_idle();

    // Starvation: dmem streak of 4 then one fetch
    dmem_req = 1; dmem_wr = 0; dmem_addr = 16'h0030;
    imem_req = 1; imem_addr = 16'h0040;
    exp3 = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
    gn = 0; prev_g = grant_id;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (prev_g == 2'd0 && grant_id != 2'd0 && gn < 8) begin gid[gn] = grant_id; gat[gn] = c; gn++; end
      prev_g = grant_id;
    end
    chk("streak_grant_cnt", {31'd0, gn >= 6}, 32'd1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("streak_gnt_%0d", k), {30'd0, gid[k]}, {30'd0, exp3[k]});
    dmem_req = 0; imem_req = 0;
    wait_idle();

    // hold_core blocks core requesters but not JTAG
    hold_core = 1; dmem_req = 1; imem_req = 1;
    seen = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (busy || grant_id != 2'd0) seen++;
    end
    chk("hold_no_grant", seen, 0);
    jtag_req = 1; jtag_wr = 0; jtag_addr = 16'h0010;
    run_until_ack(1, at);
    chk("hold_jtag_ack", at, 4);
    chk("hold_jtag_data", {16'd0, rd_data}, 32'h0000BEEF);
    jtag_req = 0;
    wait_idle();
    hold_core = 0;
    at = -1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (grant_id != 2'd0) begin at = c; break; end
    end
    chk("unhold_gnt", {30'd0, grant_id}, 32'd2);
    chk("unhold_at", at, 1);
    dmem_req = 0; imem_req = 0;
    wait_idle();

    // Reset during STROBE of a dmem write
    dmem_req = 1; dmem_wr = 1; dmem_addr = 16'h0020; dmem_wdata = 16'h1111;
    tick(); tick();
    chk("pre_rst_strobe", {30'd0, sram_wr, grant_id == 2'd2}, 32'd3);
    rst = 1;
    #1;
    chk("async_rst_out", {24'd0, busy, sram_en, sram_wr, sram_oe, grant_id, dmem_ack, jtag_ack}, 32'd0);
    seen = 0;
    repeat (2) begin
      tick();
      if (dmem_ack) seen++;
    end
    chk("rst_no_ack", seen, 0);
    rst = 0;
    tick();
    chk("rst_resume_setup", {27'd0, busy, sram_en, sram_wr, grant_id}, {27'd0, 3'b110, 2'd2});
    run_until_ack(2, at);
    chk("rst_resume_ack", at, 3);
    chk("rst_resume_mem", {16'd0, mem[16'h0020]}, 32'h00001111);
    dmem_req = 0; dmem_wr = 0;
    wait_idle();

    // ACCESS_CYCLES = 1 fetch on the second instance
    rst = 1; rst2 = 0;
    tick();
    imem_req = 1; imem_addr = 16'hFFFF;
    at = -1; seen = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (sram_wr2) seen++;
      if (imem_ack2) begin at = c; break; end
    end
    chk("ac1_ack_cycle", at, 3);
    chk("ac1_no_strobe", seen, 0);
    chk("ac1_rd_data", {16'd0, rd_data2}, 32'h00005A5A);
    chk("ac1_addr", {16'd0, sram_addr2}, 32'h0000FFFF);
    imem_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
